// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-item vending core.
// Holds the FSM state encoding, the change-coin denominations and the
// greedy denomination picker used by the change dispenser.
package vend_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CREDIT = 3'd1,
      ST_VEND   = 3'd2,
      ST_CHANGE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   localparam logic [2:0] COIN_5 = 3'd5;
   localparam logic [2:0] COIN_2 = 3'd2;
   localparam logic [2:0] COIN_1 = 3'd1;

   // Largest denomination not exceeding the amount still owed.
   function automatic logic [2:0] greedy_coin(input int unsigned due);
      logic [2:0] coin;
      if (due >= 5)
         coin = COIN_5;
      else if (due >= 2)
         coin = COIN_2;
      else
         coin = COIN_1;
      return coin;
   endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Coin-by-coin change dispenser.
// A load pulse captures the amount owed; coins are then presented greedily
// (5, 2, 1) on a valid/ready handshake. The presented coin is held stable
// until accepted, and there is a one-cycle bubble between coins.
// o_done is combinational and marks the handshake that clears the balance.
module vend_change_dispenser
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_load,
   input  logic [CREDIT_W-1:0] i_amount,
   input  logic                i_change_ready,
   output logic                o_change_valid,
   output logic [2:0]          o_change_coin,
   output logic                o_done
);

   logic [CREDIT_W-1:0] r_due;
   logic                r_valid;
   logic [2:0]          r_coin;
   logic                w_fire;

   assign w_fire         = r_valid & i_change_ready;
   assign o_done         = w_fire && (r_due == CREDIT_W'(r_coin));
   assign o_change_valid = r_valid;
   assign o_change_coin  = r_coin;

   // load balance, present next coin when idle, retire it on handshake
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_due   <= '0;
         r_valid <= 1'b0;
         r_coin  <= 3'd0;
      end else if (i_load) begin
         r_due   <= i_amount;
         r_valid <= 1'b0;
         r_coin  <= 3'd0;
      end else if (w_fire) begin
         r_due   <= r_due - CREDIT_W'(r_coin);
         r_valid <= 1'b0;
         r_coin  <= 3'd0;
      end else if (!r_valid && (r_due != '0)) begin
         r_valid <= 1'b1;
         r_coin  <= greedy_coin(32'(r_due));
      end
   end

endmodule

// File: rtl/vend_core_multi.sv
// Multi-item vending controller core: credit escrow, per-item stock,
// purchase arbitration and change dispensing.
// Optional feature macro: ESCROW_TIMEOUT_EN -- when defined, credit left
// untouched for TIMEOUT_CYC cycles in CREDIT is refunded as if cancelled.
//
// state  | meaning
// IDLE   | no credit held; coins accepted, restock honoured
// CREDIT | credit held; cancel > coin > purchase
// VEND   | one-cycle vend strobe, stock decrement, change computed
// CHANGE | dispensing change coin by coin
// ERROR  | failed purchase; hold ERR_HOLD cycles, credit retained
module vend_core_multi
   import vend_pkg::*;
#(
   parameter int N_ITEMS    = 4,
   parameter int STOCK_W    = 4,
   parameter int STOCK_MAX  = 9,
   parameter int CREDIT_W   = 8,
   parameter int CREDIT_MAX = 99,
   parameter int ERR_HOLD   = 16,
`ifdef ESCROW_TIMEOUT_EN
   parameter int TIMEOUT_CYC = 1_000_000,
`endif
   localparam int SEL_W = $clog2(N_ITEMS)
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_coin_pulse,
   input  logic [CREDIT_W-1:0]         i_coin_value,
   input  logic                        i_purchase_req,
   input  logic                        i_cancel_req,
   input  logic [SEL_W-1:0]            i_item_sel,
   input  logic                        i_restock,
   input  logic [N_ITEMS*CREDIT_W-1:0] i_price_flat,
   input  logic                        i_change_ready,
   output logic [CREDIT_W-1:0]         o_credit,
   output logic [N_ITEMS*STOCK_W-1:0]  o_stock_flat,
   output logic                        o_vend_pulse,
   output logic [SEL_W-1:0]            o_vend_item,
   output logic                        o_coin_reject,
   output logic                        o_error_pulse,
   output logic                        o_change_valid,
   output logic [2:0]                  o_change_coin,
   output logic [2:0]                  o_state
);

   localparam int ERR_W = $clog2(ERR_HOLD + 1);
   localparam logic [ERR_W-1:0]   ERR_LOAD   = ERR_W'(ERR_HOLD - 1);
   localparam logic [STOCK_W-1:0] STOCK_LOAD = STOCK_W'(STOCK_MAX);
   localparam logic [CREDIT_W:0]  SUM_LIMIT  = (CREDIT_W + 1)'(CREDIT_MAX);

   state_t              r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [STOCK_W-1:0]  r_stock [N_ITEMS];
   logic                r_vend_pulse;
   logic [SEL_W-1:0]    r_vend_item;
   logic                r_coin_reject;
   logic                r_error_pulse;
   logic [ERR_W-1:0]    r_err_cnt;
   logic                r_chg_load;
   logic [CREDIT_W-1:0] r_chg_amt;

   logic [CREDIT_W-1:0] w_price [N_ITEMS];
   logic [CREDIT_W:0]   w_sum;
   logic                w_coin_ok;
   logic                w_buy_ok;
   logic [CREDIT_W-1:0] w_vend_price;
   logic                w_chg_done;
   logic                w_tmo_expired;

   for (genvar g = 0; g < N_ITEMS; g++) begin : g_items
      assign w_price[g] = i_price_flat[g*CREDIT_W +: CREDIT_W];
      assign o_stock_flat[g*STOCK_W +: STOCK_W] = r_stock[g];
   end

   // sum kept one bit wider so an oversized coin is rejected, never wrapped
   assign w_sum        = {1'b0, r_credit} + {1'b0, i_coin_value};
   assign w_coin_ok    = (w_sum <= SUM_LIMIT);
   assign w_buy_ok     = (r_stock[i_item_sel] != '0) && (r_credit >= w_price[i_item_sel]);
   assign w_vend_price = w_price[r_vend_item];

`ifdef ESCROW_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

   logic [TMO_W-1:0] r_tmo;
   logic             w_any_strobe;

   assign w_any_strobe = i_coin_pulse | i_purchase_req | i_cancel_req;

   // escrow timer: reloaded by customer activity or outside CREDIT, runs down while credit sits
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_tmo <= TMO_LOAD;
      else if (w_any_strobe || (r_state != ST_CREDIT))
         r_tmo <= TMO_LOAD;
      else if (r_tmo != '0)
         r_tmo <= r_tmo - 1'b1;
   end

   assign w_tmo_expired = (r_state == ST_CREDIT) && (r_tmo == '0) && !w_any_strobe;
`else
   assign w_tmo_expired = 1'b0;
`endif

   // main controller: state, credit, stock and registered strobes
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_credit      <= '0;
         for (int i = 0; i < N_ITEMS; i++)
            r_stock[i] <= STOCK_LOAD;
         r_vend_pulse  <= 1'b0;
         r_vend_item   <= '0;
         r_coin_reject <= 1'b0;
         r_error_pulse <= 1'b0;
         r_err_cnt     <= '0;
         r_chg_load    <= 1'b0;
         r_chg_amt     <= '0;
      end else begin
         r_vend_pulse  <= 1'b0;
         r_coin_reject <= 1'b0;
         r_error_pulse <= 1'b0;
         r_chg_load    <= 1'b0;

         if (i_coin_pulse && (r_state != ST_IDLE) && (r_state != ST_CREDIT))
            r_coin_reject <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (i_restock)
                  r_stock[i_item_sel] <= STOCK_LOAD;
               if (i_coin_pulse) begin
                  if (w_coin_ok) begin
                     r_credit <= w_sum[CREDIT_W-1:0];
                     r_state  <= ST_CREDIT;
                  end else begin
                     r_coin_reject <= 1'b1;
                  end
               end
            end

            ST_CREDIT: begin
               if (i_cancel_req || w_tmo_expired) begin
                  r_chg_amt <= r_credit;
                  r_credit  <= '0;
                  if (r_credit != '0) begin
                     r_chg_load <= 1'b1;
                     r_state    <= ST_CHANGE;
                  end else begin
                     r_state    <= ST_IDLE;
                  end
               end else if (i_coin_pulse) begin
                  if (w_coin_ok)
                     r_credit <= w_sum[CREDIT_W-1:0];
                  else
                     r_coin_reject <= 1'b1;
               end else if (i_purchase_req) begin
                  if (w_buy_ok) begin
                     r_vend_pulse <= 1'b1;
                     r_vend_item  <= i_item_sel;
                     r_state      <= ST_VEND;
                  end else begin
                     r_error_pulse <= 1'b1;
                     r_err_cnt     <= ERR_LOAD;
                     r_state       <= ST_ERROR;
                  end
               end
            end

            ST_VEND: begin
               r_stock[r_vend_item] <= r_stock[r_vend_item] - 1'b1;
               r_chg_amt            <= r_credit - w_vend_price;
               r_credit             <= '0;
               if (r_credit != w_vend_price) begin
                  r_chg_load <= 1'b1;
                  r_state    <= ST_CHANGE;
               end else begin
                  r_state    <= ST_IDLE;
               end
            end

            ST_CHANGE: begin
               if (w_chg_done)
                  r_state <= ST_IDLE;
            end

            ST_ERROR: begin
               if (r_err_cnt == '0)
                  r_state <= (r_credit == '0) ? ST_IDLE : ST_CREDIT;
               else
                  r_err_cnt <= r_err_cnt - 1'b1;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   vend_change_dispenser #(
      .CREDIT_W (CREDIT_W)
   ) u_change (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_load         (r_chg_load),
      .i_amount       (r_chg_amt),
      .i_change_ready (i_change_ready),
      .o_change_valid (o_change_valid),
      .o_change_coin  (o_change_coin),
      .o_done         (w_chg_done)
   );

   assign o_credit      = r_credit;
   assign o_vend_pulse  = r_vend_pulse;
   assign o_vend_item   = r_vend_item;
   assign o_coin_reject = r_coin_reject;
   assign o_error_pulse = r_error_pulse;
   assign o_state       = r_state;

endmodule

// File: tb/tb_vend_core_multi.sv
// Self-checking bench for vend_core_multi: directed scenarios followed by a
// randomized transaction phase, all checked against a transaction-level model.
module tb_vend_core_multi;

   localparam int N    = 4;
   localparam int SW   = 4;
   localparam int CW   = 8;
   localparam int SMAX = 9;
   localparam int CMAX = 99;
   localparam int EH   = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          coin_pulse = 1'b0;
   logic [CW-1:0] coin_value = '0;
   logic          purchase_req = 1'b0;
   logic          cancel_req = 1'b0;
   logic [1:0]    item_sel = '0;
   logic          restock = 1'b0;
   logic [N*CW-1:0] price_flat = '0;
   logic          change_ready = 1'b0;

   logic [CW-1:0]   o_credit;
   logic [N*SW-1:0] o_stock_flat;
   logic            o_vend_pulse;
   logic [1:0]      o_vend_item;
   logic            o_coin_reject;
   logic            o_error_pulse;
   logic            o_change_valid;
   logic [2:0]      o_change_coin;
   logic [2:0]      o_state;

   int n_assert = 0;
   int n_fail   = 0;

   // transaction-level model: 0 idle, 1 credit held (state codes are architectural)
   int m_credit;
   int m_state;
   int m_stock [N];
   int m_price [N];

   vend_core_multi #(
`ifdef ESCROW_TIMEOUT_EN
      .TIMEOUT_CYC (100),
`endif
      .N_ITEMS    (N),
      .STOCK_W    (SW),
      .STOCK_MAX  (SMAX),
      .CREDIT_W   (CW),
      .CREDIT_MAX (CMAX),
      .ERR_HOLD   (EH)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_coin_pulse   (coin_pulse),
      .i_coin_value   (coin_value),
      .i_purchase_req (purchase_req),
      .i_cancel_req   (cancel_req),
      .i_item_sel     (item_sel),
      .i_restock      (restock),
      .i_price_flat   (price_flat),
      .i_change_ready (change_ready),
      .o_credit       (o_credit),
      .o_stock_flat   (o_stock_flat),
      .o_vend_pulse   (o_vend_pulse),
      .o_vend_item    (o_vend_item),
      .o_coin_reject  (o_coin_reject),
      .o_error_pulse  (o_error_pulse),
      .o_change_valid (o_change_valid),
      .o_change_coin  (o_change_coin),
      .o_state        (o_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, summary not printed");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_stock_flat();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         v[i*SW +: SW] = SW'(m_stock[i]);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_coin(input int v);
      bit acc;
      acc = ((m_state == 0) || (m_state == 1)) && (m_credit + v <= CMAX);
      coin_value = CW'(v);
      coin_pulse = 1'b1;
      tick();
      coin_pulse = 1'b0;
      if (acc) begin
         m_credit += v;
         m_state   = 1;
      end
      chk("coin_reject", o_coin_reject, 32'(!acc));
      chk("credit_after_coin", o_credit, m_credit);
      chk("state_after_coin", o_state, m_state);
   endtask

   task automatic do_restock(input int item);
      if (m_state == 0)
         m_stock[item] = SMAX;
      item_sel = 2'(item);
      restock  = 1'b1;
      tick();
      restock  = 1'b0;
      chk("stock_after_restock", o_stock_flat, exp_stock_flat());
   endtask

   // Collect change coins through the handshake and compare with the greedy breakdown.
   task automatic collect(input int due, input int stall_idx, input int stall_len, input bit rnd);
      int exp_q[$];
      int got_q[$];
      int rem;
      int cyc;
      int left;
      bit stalled;
      logic [2:0] held;
      rem = due;
      while (rem >= 5) begin exp_q.push_back(5); rem -= 5; end
      while (rem >= 2) begin exp_q.push_back(2); rem -= 2; end
      if (rem == 1) exp_q.push_back(1);
      left = stall_len;
      cyc  = 0;
      while ((o_state == 3'd3) && (cyc < 2000)) begin
         if (o_change_valid && (got_q.size() == stall_idx) && (left > 0)) begin
            change_ready = 1'b0;
            left--;
         end else begin
            change_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         purchase_req = rnd && (cyc == 1);
         cancel_req   = rnd && (cyc == 2);
         stalled = o_change_valid && !change_ready;
         held    = o_change_coin;
         if (o_change_valid && change_ready)
            got_q.push_back(int'(o_change_coin));
         tick();
         cyc++;
         purchase_req = 1'b0;
         cancel_req   = 1'b0;
         if (stalled) begin
            chk("stall_valid_held", o_change_valid, 1);
            chk("stall_coin_held", o_change_coin, held);
         end
      end
      change_ready = 1'b0;
      chk("change_coin_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk("change_coin_value", (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
      chk("change_valid_after", o_change_valid, 0);
      chk("state_after_change", o_state, 0);
      m_state = 0;
   endtask

   task automatic wait_error();
      int cyc;
      cyc = 1;
      while ((o_state == 3'd4) && (cyc < 200)) begin
         coin_pulse = (cyc == 3);
         coin_value = 8'd1;
         cancel_req = (cyc == 7);
         purchase_req = (cyc == 9);
         tick();
         coin_pulse = 1'b0;
         cancel_req = 1'b0;
         purchase_req = 1'b0;
         if (cyc == 3)
            chk("reject_in_error", o_coin_reject, 1);
         if (o_state == 3'd4)
            cyc++;
      end
      chk("error_length", cyc, EH);
      m_state = (m_credit > 0) ? 1 : 0;
      chk("state_after_error", o_state, m_state);
      chk("credit_after_error", o_credit, m_credit);
   endtask

   task automatic do_purchase(input int item, input bit rnd);
      bit ok;
      int chg;
      ok = (m_stock[item] > 0) && (m_credit >= m_price[item]);
      item_sel     = 2'(item);
      purchase_req = 1'b1;
      tick();
      purchase_req = 1'b0;
      if (!ok) begin
         chk("error_state", o_state, 4);
         chk("error_pulse", o_error_pulse, 1);
         chk("credit_kept", o_credit, m_credit);
         wait_error();
      end else begin
         chk("vend_state", o_state, 2);
         chk("vend_pulse", o_vend_pulse, 1);
         chk("vend_item", o_vend_item, item);
         chg = m_credit - m_price[item];
         m_stock[item]--;
         m_credit = 0;
         tick();
         chk("vend_pulse_low", o_vend_pulse, 0);
         chk("credit_after_vend", o_credit, 0);
         chk("stock_after_vend", o_stock_flat, exp_stock_flat());
         chk("state_after_vend", o_state, (chg > 0) ? 3 : 0);
         m_state = 0;
         if (chg > 0)
            collect(chg, -1, 0, rnd);
      end
   endtask

   task automatic do_cancel(input bit with_coin, input int stall_idx, input int stall_len, input bit rnd);
      int chg;
      chg = m_credit;
      cancel_req = 1'b1;
      coin_pulse = with_coin;
      coin_value = 8'd3;
      tick();
      cancel_req = 1'b0;
      coin_pulse = 1'b0;
      m_credit = 0;
      m_state  = 0;
      chk("credit_after_cancel", o_credit, 0);
      chk("state_after_cancel", o_state, (chg > 0) ? 3 : 0);
      if (chg > 0)
         collect(chg, stall_idx, stall_len, rnd);
   endtask

   initial begin
      int r;
      int wcyc;
      m_price[0] = 5;
      m_price[1] = 5;
      m_price[2] = 3;
      m_price[3] = 7;
      for (int i = 0; i < N; i++) begin
         price_flat[i*CW +: CW] = CW'(m_price[i]);
         m_stock[i] = SMAX;
      end
      m_credit = 0;
      m_state  = 0;

      #2 rst_n = 1'b0;
      #1;
      chk("reset_state", o_state, 0);
      chk("reset_credit", o_credit, 0);
      chk("reset_stock", o_stock_flat, exp_stock_flat());
      chk("reset_change_valid", o_change_valid, 0);
      chk("reset_change_coin", o_change_coin, 0);
      chk("reset_vend_pulse", o_vend_pulse, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // coins 5,2 then buy item1 with change of one 2-coin
      do_coin(5);
      do_coin(2);
      do_restock(1);
      do_purchase(1, 0);

      // insufficient credit -> ERROR for 16 cycles, credit retained
      do_coin(3);
      do_purchase(0, 0);
      do_cancel(0, -1, 0, 0);

      // ceiling: 98 + 5 rejected, refund 98 with a stall on the second coin
      do_coin(50);
      do_coin(48);
      do_coin(5);
      do_cancel(0, 1, 3, 0);
      do_coin(99);
      do_coin(1);
      do_cancel(0, -1, 0, 0);

      // drain item2, failed purchase, restock only honoured in IDLE
      for (int k = 0; k < SMAX; k++) begin
         do_coin(3);
         do_purchase(2, 0);
      end
      do_coin(10);
      do_restock(2);
      do_purchase(2, 0);
      do_cancel(0, -1, 0, 0);
      do_restock(2);

      // coin and cancel in the same cycle: cancel wins
      do_coin(4);
      do_cancel(1, -1, 0, 0);

      // randomized transactions
      for (int it = 0; it < 80; it++) begin
         if (m_state == 0) begin
            if ($urandom_range(0, 3) == 0)
               do_restock($urandom_range(0, N - 1));
            else
               do_coin($urandom_range(1, 40));
         end else begin
            r = $urandom_range(0, 9);
            if (r < 5)
               do_coin($urandom_range(1, 40));
            else if (r < 9)
               do_purchase($urandom_range(0, N - 1), 1);
            else
               do_cancel(0, -1, 0, 1);
         end
      end

      // reset in the middle of a refund
      if (m_state == 1)
         do_cancel(0, -1, 0, 0);
      do_coin(20);
      cancel_req = 1'b1;
      tick();
      cancel_req = 1'b0;
      wcyc = 0;
      while (!o_change_valid && (wcyc < 10)) begin
         tick();
         wcyc++;
      end
      chk("refund_started", o_change_valid, 1);
      change_ready = 1'b1;
      tick();
      change_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      m_credit = 0;
      m_state  = 0;
      for (int i = 0; i < N; i++)
         m_stock[i] = SMAX;
      chk("midchg_reset_state", o_state, 0);
      chk("midchg_reset_credit", o_credit, 0);
      chk("midchg_reset_stock", o_stock_flat, exp_stock_flat());
      chk("midchg_reset_valid", o_change_valid, 0);
      chk("midchg_reset_coin", o_change_coin, 0);
      chk("midchg_reset_reject", o_coin_reject, 0);
      chk("midchg_reset_error", o_error_pulse, 0);
      chk("midchg_reset_vend", o_vend_pulse, 0);
      tick();
      rst_n = 1'b1;
      change_ready = 1'b1;
      tick();
      tick();
      chk("after_reset_state", o_state, 0);
      chk("after_reset_valid", o_change_valid, 0);
      change_ready = 1'b0;

`ifdef ESCROW_TIMEOUT_EN
      // escrow timeout: untouched credit of 6 refunded as 5,1
      do_coin(6);
      for (int k = 0; k < 98; k++)
         tick();
      chk("timeout_still_credit", o_state, 1);
      wcyc = 0;
      while ((o_state != 3'd3) && (wcyc < 6)) begin
         tick();
         wcyc++;
      end
      chk("timeout_refund_state", o_state, 3);
      chk("timeout_credit_zero", o_credit, 0);
      m_credit = 0;
      collect(6, -1, 0, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
